grid_sequencer: RTL and testbench
=================================

Name: grid_sequencer

Overview:
- Program sequencer for the cellular-automaton core grid: fetches instructions from program memory and broadcasts instruction, next PC, next SP and global enable to every core.
- Runs a requested number of generations. Each generation executes from PC 0 until an END instruction.
- Owns the call/return stack and the generation counter, and counts cycles in which any core reports divergence.
- Sits between the host/top-level control and the core array.

Parameters:
- INSTR_W, 32, instruction word width; equals the cores' instruction type width.
- PC_W, 8, program counter width; equals the cores' PC type width.
- SP_W, 4, stack pointer width; equals the cores' SP type width.
- STACK_DEPTH, 8, return stack entries; must be ≤ 2**SP_W − 1.
- OPC_W, 5, opcode field width, taken from instruction[INSTR_W-1 -: OPC_W].
- OP_END, 5'h1F, opcode that ends a generation.
- OP_JMP, 5'h1C, unconditional jump; target is instruction[PC_W-1:0].
- OP_CALL, 5'h1D, call; target is instruction[PC_W-1:0].
- OP_RET, 5'h1E, return.
- GEN_W, 16, generation count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle launch request; accepted only in IDLE or ERROR.
- abort  in  1  synchronous stop; returns to IDLE.
- generations  in  GEN_W  number of generations to run; sampled when start is accepted.
- imem_rd_en  out  1  program memory read strobe.
- imem_addr  out  PC_W  program memory address.
- imem_data  in  INSTR_W  read data, valid exactly 1 cycle after imem_rd_en.
- instruction  out  INSTR_W  broadcast instruction.
- next_program_counter  out  PC_W  broadcast next PC.
- next_stack_pointer  out  SP_W  broadcast next SP.
- global_enable  out  1  one-cycle execute strobe to all cores.
- diverge_any  in  1  OR of all cores' diverge outputs.
- busy  out  1  high in FETCH, WAIT, EXEC.
- done  out  1  one-cycle pulse when the final generation completes.
- stack_error  out  1  sticky stack overflow/underflow flag.
- gen_count  out  GEN_W  generations completed in the current run.
- diverge_cycles  out  16  saturating count of EXEC cycles with diverge_any high.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; pc = 0; sp = 0; stack entries need not be cleared.
  - All outputs are 0.
- States: IDLE, FETCH, WAIT, EXEC, ERROR.
- IDLE/ERROR + start:
  - Latch generations; clear gen_count, diverge_cycles, stack_error, pc and sp.
  - If generations == 0: pulse done on the next cycle and stay in IDLE; no fetch is issued.
  - Otherwise go to FETCH.
- FETCH: imem_rd_en = 1, imem_addr = pc; go to WAIT.
- WAIT: register imem_data into instruction; go to EXEC.
- EXEC:
  - global_enable = 1 for exactly this cycle; instruction is held stable.
  - If diverge_any is high, increment diverge_cycles (saturates at 16'hFFFF).
  - Decode by opcode:
    - Normal op: next_program_counter = pc+1 (wraps mod 2**PC_W); next_stack_pointer = sp.
    - JMP: next_program_counter = target; SP unchanged.
    - CALL with sp < STACK_DEPTH: stack[sp] = pc+1; sp+1; PC = target.
    - CALL with sp == STACK_DEPTH: global_enable is forced 0, stack_error is set, go to ERROR.
    - RET with sp > 0: PC = stack[sp−1]; sp−1.
    - RET with sp == 0: global_enable is forced 0, stack_error is set, go to ERROR.
    - END: next_program_counter = 0, next_stack_pointer = 0, and gen_count increments.
  - After END: if the new gen_count == latched generations, pulse done and go to IDLE; otherwise go to FETCH at pc 0.
  - After any other successful op: pc and sp take the next values; go to FETCH.
- Throughput: 3 cycles per instruction, with global_enable high 1 cycle in 3.
- The broadcast next_program_counter and next_stack_pointer are held between EXEC cycles.
- abort:
  - Takes priority over all transitions.
  - Next state is IDLE; no done pulse; global_enable is 0 in that cycle; gen_count is held.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and start is dropped.
- ERROR holds all broadcast outputs; busy = 0; exits only on start.
- Reset asserted mid-run: immediate return to the reset state; no done pulse.

Test Plan:
- generations=2; program {ADD, ADD, END} → global_enable pulses at 3-cycle spacing; 6 enables total; gen_count 1 then 2; done pulse after the 6th EXEC; next PC sequence 1, 2, 0, 1, 2, 0.
- Program {CALL 4, END, –, –, ADD, RET}, generations=1 → next_program_counter sequence 4, 5, 1, 0; next_stack_pointer sequence 1, 1, 0, 0; done asserted; stack_error = 0.
- Recursive CALL 0 at address 0 with STACK_DEPTH=8 → 8 calls succeed; the 9th sets stack_error, state goes to ERROR, global_enable stays 0 in that EXEC; no done pulse; a later start clears stack_error.
- RET at address 0 → stack_error set on the first EXEC, ERROR entered; start with generations=0 → done pulse next cycle, no imem_rd_en.
- diverge_any held high for the whole run of 3 instructions × 2 generations → diverge_cycles = 6; with diverge_any high only in non-EXEC cycles → diverge_cycles = 0.
- abort asserted in WAIT during generation 1 of 3 → IDLE next cycle; done never pulses; gen_count = 0. rst pulled low mid-EXEC → all outputs 0 asynchronously.

Source files
------------

// File: rtl/grid_sequencer.sv
// Program sequencer for the cellular-automaton core grid: fetches, decodes flow control,
// broadcasts instruction/next PC/next SP with a one-cycle global enable per instruction.
// state | meaning
// IDLE  | waiting for start; ERROR | stack fault, outputs held until start
// FETCH | read strobe at pc; WAIT | capture read data; EXEC | broadcast + update pc/sp
module grid_sequencer #(
  parameter int INSTR_W     = 32,
  parameter int PC_W        = 8,
  parameter int SP_W        = 4,
  parameter int STACK_DEPTH = 8,
  parameter int OPC_W       = 5,
  parameter logic [OPC_W-1:0] OP_END  = 5'h1F,
  parameter logic [OPC_W-1:0] OP_JMP  = 5'h1C,
  parameter logic [OPC_W-1:0] OP_CALL = 5'h1D,
  parameter logic [OPC_W-1:0] OP_RET  = 5'h1E,
  parameter int GEN_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [GEN_W-1:0]   generations,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    next_program_counter,
  output logic [SP_W-1:0]    next_stack_pointer,
  output logic               global_enable,
  input  logic               diverge_any,
  output logic               busy,
  output logic               done,
  output logic               stack_error,
  output logic [GEN_W-1:0]   gen_count,
  output logic [15:0]        diverge_cycles
);

  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] LP_DEPTH = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_ERROR} state_t;

  state_t             r_state, w_next;
  logic [PC_W-1:0]    r_pc, r_npc;
  logic [SP_W-1:0]    r_sp, r_nsp;
  logic [PC_W-1:0]    r_stack [STACK_DEPTH];
  logic [INSTR_W-1:0] r_instr;
  logic [GEN_W-1:0]   r_gen_target, r_gen_count;
  logic [15:0]        r_div;
  logic               r_stack_err, r_done;

  logic [OPC_W-1:0]   w_opc;
  logic [PC_W-1:0]    w_target, w_pc_inc, w_npc;
  logic [SP_W-1:0]    w_nsp;
  logic [SI_W-1:0]    w_call_idx, w_ret_idx;
  logic [GEN_W-1:0]   w_gen_next;
  logic               w_err, w_is_end, w_exec_ok, w_start_ok;

  always_comb begin
    w_opc      = r_instr[INSTR_W-1 -: OPC_W];
    w_target   = r_instr[PC_W-1:0];
    w_pc_inc   = r_pc + PC_W'(1);
    w_call_idx = SI_W'(r_sp);
    w_ret_idx  = SI_W'(r_sp - SP_W'(1));
    w_gen_next = r_gen_count + GEN_W'(1);
    w_start_ok = start && !abort && (r_state == S_IDLE || r_state == S_ERROR);
    w_npc      = w_pc_inc;
    w_nsp      = r_sp;
    w_err      = 1'b0;
    w_is_end   = 1'b0;
    case (w_opc)
      OP_JMP: w_npc = w_target;
      OP_CALL: begin
        if (r_sp >= LP_DEPTH) begin
          w_err = 1'b1;
        end else begin
          w_npc = w_target;
          w_nsp = r_sp + SP_W'(1);
        end
      end
      OP_RET: begin
        if (r_sp == '0) begin
          w_err = 1'b1;
        end else begin
          w_npc = r_stack[w_ret_idx];
          w_nsp = r_sp - SP_W'(1);
        end
      end
      OP_END: begin
        w_npc    = '0;
        w_nsp    = '0;
        w_is_end = 1'b1;
      end
      default: ;
    endcase
    w_exec_ok = (r_state == S_EXEC) && !abort && !w_err;

    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if (w_start_ok) w_next = (generations == '0) ? S_IDLE : S_FETCH;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_EXEC;
      S_EXEC: begin
        if (w_err)                                       w_next = S_ERROR;
        else if (w_is_end && w_gen_next == r_gen_target) w_next = S_IDLE;
        else                                             w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_sp         <= '0;
      r_npc        <= '0;
      r_nsp        <= '0;
      r_instr      <= '0;
      r_gen_target <= '0;
      r_gen_count  <= '0;
      r_div        <= '0;
      r_stack_err  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (w_start_ok) begin
        r_gen_target <= generations;
        r_gen_count  <= '0;
        r_div        <= '0;
        r_stack_err  <= 1'b0;
        r_pc         <= '0;
        r_sp         <= '0;
        if (generations == '0) r_done <= 1'b1;
      end
      if (r_state == S_WAIT) r_instr <= imem_data;
      if (r_state == S_EXEC) begin
        if (diverge_any && r_div != 16'hFFFF) r_div <= r_div + 16'd1;
        if (w_err && !abort) r_stack_err <= 1'b1;
        if (w_exec_ok) begin
          r_pc  <= w_npc;
          r_sp  <= w_nsp;
          r_npc <= w_npc;
          r_nsp <= w_nsp;
          if (w_is_end) begin
            r_gen_count <= w_gen_next;
            if (w_gen_next == r_gen_target) r_done <= 1'b1;
          end
        end
      end
    end
  end

  // Return stack needs no reset: entries are only read below a valid sp.
  always_ff @(posedge clk) begin
    if (w_exec_ok && w_opc == OP_CALL) r_stack[w_call_idx] <= w_pc_inc;
  end

  assign imem_rd_en           = (r_state == S_FETCH);
  assign imem_addr            = r_pc;
  assign instruction          = r_instr;
  assign global_enable        = w_exec_ok;
  assign next_program_counter = w_exec_ok ? w_npc : r_npc;
  assign next_stack_pointer   = w_exec_ok ? w_nsp : r_nsp;
  assign busy                 = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EXEC);
  assign done                 = r_done;
  assign stack_error          = r_stack_err;
  assign gen_count            = r_gen_count;
  assign diverge_cycles       = r_div;

endmodule

// File: tb/tb_grid_sequencer.sv
// Scoreboarded bench for grid_sequencer: an instruction-level interpreter predicts every
// broadcast; a monitor pops and compares on each global_enable.
module tb_grid_sequencer;

  localparam logic [4:0] OP_END = 5'h1F, OP_JMP = 5'h1C, OP_CALL = 5'h1D, OP_RET = 5'h1E;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] generations = '0;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instruction;
  logic [7:0]  next_program_counter;
  logic [3:0]  next_stack_pointer;
  logic        global_enable;
  logic        diverge_any = 1'b0;
  logic        busy, done, stack_error;
  logic [15:0] gen_count, diverge_cycles;

  grid_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .generations(generations),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .next_program_counter(next_program_counter),
    .next_stack_pointer(next_stack_pointer), .global_enable(global_enable),
    .diverge_any(diverge_any), .busy(busy), .done(done), .stack_error(stack_error),
    .gen_count(gen_count), .diverge_cycles(diverge_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  npc;
    logic [3:0]  nsp;
  } exp_t;

  logic [31:0] prog [256];
  exp_t q_exp[$];
  exp_t q_model[$];
  int n_total = 0, n_pass = 0;
  int n_done = 0, n_rd = 0, cyc = 0;
  int dv_mode = 0;

  always @(posedge clk) if (imem_rd_en) imem_data <= prog[imem_addr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares each broadcast against the scoreboard and checks issue spacing.
  initial begin
    int last_en;
    bit have_prev;
    exp_t e;
    have_prev = 0;
    last_en = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) n_done++;
      if (imem_rd_en === 1'b1) n_rd++;
      if (busy !== 1'b1) have_prev = 0;
      if (global_enable === 1'b1) begin
        if (have_prev) check("enable_spacing", 128'(cyc - last_en), 128'(3));
        have_prev = 1;
        last_en = cyc;
        if (q_exp.size() == 0) begin
          check("unexpected_enable", 128'(1), 128'(0));
        end else begin
          e = q_exp.pop_front();
          check("instruction", 128'(instruction), 128'(e.ins));
          check("next_pc", 128'(next_program_counter), 128'(e.npc));
          check("next_sp", 128'(next_stack_pointer), 128'(e.nsp));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    diverge_any = (dv_mode == 1) ? 1'b1 : (dv_mode == 2) ? imem_rd_en : 1'b0;
  end

  // Instruction-level interpreter of the program in prog[].
  function automatic void model(input int gens, output bit err, output int n_exec,
                                output int gd, output bit too_long);
    int pc, sp, n;
    int stk [8];
    logic [31:0] ins;
    exp_t e;
    pc = 0; sp = 0; n = 0; gd = 0; err = 0; too_long = 0;
    q_model.delete();
    while (gd < gens && !err && !too_long) begin
      ins = prog[pc];
      e.ins = ins;
      case (ins[31:27])
        OP_END:  begin pc = 0; sp = 0; gd++; end
        OP_JMP:  pc = int'(ins[7:0]);
        OP_CALL: begin
          if (sp == 8) err = 1;
          else begin stk[sp] = (pc + 1) % 256; sp++; pc = int'(ins[7:0]); end
        end
        OP_RET: begin
          if (sp == 0) err = 1;
          else begin sp--; pc = stk[sp]; end
        end
        default: pc = (pc + 1) % 256;
      endcase
      if (!err) begin
        e.npc = 8'(pc);
        e.nsp = 4'(sp);
        q_model.push_back(e);
        n++;
      end
      if (n > 300) too_long = 1;
    end
    n_exec = n + (err ? 1 : 0);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = {OP_END, 27'h0};
  endtask

  task automatic do_run(input int gens, input int dmode);
    bit err, tl;
    int n_exec, gd, done0, rd0, c;
    model(gens, err, n_exec, gd, tl);
    q_exp = q_model;
    dv_mode = dmode;
    done0 = n_done;
    rd0 = n_rd;
    @(negedge clk);
    start = 1'b1;
    generations = 16'(gens);
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (busy === 1'b1) check("run_timeout", 128'(1), 128'(0));
    @(negedge clk);
    check("scoreboard_drained", 128'(q_exp.size()), 128'(0));
    check("done_pulses", 128'(n_done - done0), 128'(err ? 0 : 1));
    check("stack_error", 128'(stack_error), 128'(err));
    check("gen_count", 128'(gen_count), 128'(gd));
    check("diverge_cycles", 128'(diverge_cycles), 128'(dmode == 1 ? n_exec : 0));
    if (gens == 0) check("no_fetch_on_zero", 128'(n_rd - rd0), 128'(0));
    q_exp.delete();
    dv_mode = 0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({imem_rd_en, imem_addr, instruction, next_program_counter,
                      next_stack_pointer, global_enable, busy, done, stack_error,
                      gen_count, diverge_cycles}), 128'(0));
  endtask

  task automatic random_prog();
    int len, k;
    clear_prog();
    len = $urandom_range(3, 12);
    for (int pc = 0; pc < len - 1; pc++) begin
      k = $urandom_range(0, 9);
      case (k)
        6: prog[pc] = {OP_JMP, 19'($urandom), 8'($urandom_range(pc + 1, len - 1))};
        7: prog[pc] = {OP_CALL, 19'($urandom), 8'($urandom_range(pc + 1, len - 1))};
        8: prog[pc] = {OP_RET, 27'($urandom)};
        9: prog[pc] = {OP_END, 27'($urandom)};
        default: prog[pc] = {5'($urandom_range(0, 27)), 27'($urandom)};
      endcase
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit err, tl;
    int n_exec, gd, done0, rd0, c, tries;
    clear_prog();
    #1;
    check_all_zero("reset_outputs");
    #20;
    @(negedge clk);
    rst = 1'b1;

    // Two generations of {ADD, ADD, END}; diverge held high then only during fetch.
    prog[0] = {5'h00, 27'h123};
    prog[1] = {5'h01, 27'h456};
    prog[2] = {OP_END, 27'h0};
    do_run(2, 1);
    do_run(2, 2);

    // Call/return program.
    clear_prog();
    prog[0] = {OP_CALL, 19'h0, 8'd4};
    prog[1] = {OP_END, 27'h0};
    prog[4] = {5'h02, 27'h0};
    prog[5] = {OP_RET, 27'h0};
    do_run(1, 0);

    // Unbounded recursion overflows on the ninth call.
    clear_prog();
    prog[0] = {OP_CALL, 19'h0, 8'd0};
    do_run(1, 1);
    check("error_not_busy", 128'(busy), 128'(0));

    // Underflow, then a zero-generation start out of ERROR.
    clear_prog();
    prog[0] = {OP_RET, 27'h0};
    do_run(1, 0);
    do_run(0, 0);

    // Abort during WAIT of the first instruction.
    clear_prog();
    prog[0] = {5'h00, 27'h0};
    prog[1] = {5'h00, 27'h0};
    prog[2] = {OP_END, 27'h0};
    done0 = n_done;
    @(negedge clk);
    start = 1'b1;
    generations = 16'd3;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (imem_rd_en !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_to_idle", 128'(busy), 128'(0));
    repeat (6) @(negedge clk);
    check("abort_gen_count", 128'(gen_count), 128'(0));
    check("abort_no_done", 128'(n_done - done0), 128'(0));

    // Start and abort together in IDLE: abort wins.
    rd0 = n_rd;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_beats_start", 128'({busy, 8'(n_rd - rd0)}), 128'(0));

    // Reset mid-EXEC.
    model(3, err, n_exec, gd, tl);
    q_exp = q_model;
    done0 = n_done;
    start = 1'b1;
    generations = 16'd3;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (global_enable !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    check("reached_exec", 128'(global_enable), 128'(1));
    rst = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    q_exp.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_no_done", 128'(n_done - done0), 128'(0));

    // Random programs.
    for (int r = 0; r < 20; r++) begin
      tries = 0;
      do begin
        random_prog();
        model(3, err, n_exec, gd, tl);
        tries++;
      end while (tl && tries < 50);
      if (!tl) do_run($urandom_range(1, 3), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
